// File: rtl/mem_arbiter.sv
// ============================================================================
// mem_arbiter: two-requester (fetch/data) arbiter for a single shared memory port.
// Build option: define MEM_ARBITER_ROUND_ROBIN_EN for round-robin on contention,
// otherwise data has fixed priority over instruction fetch.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mem_arbiter #(
   parameter int MEM_LATENCY = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        i_req,
   input  logic [31:0] i_addr,
   output logic [31:0] i_rdata,
   output logic        i_ack,
   input  logic        d_req,
   input  logic        d_we,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   output logic [31:0] d_rdata,
   output logic        d_ack,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic        mem_we,
   input  logic [31:0] mem_rdata,
   output logic        busy
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_ACK    = 2'd2
   } state_t;

   localparam logic [3:0] C_LAT = 4'(MEM_LATENCY);

   state_t      state_q;
   logic [3:0]  cnt_q;
   logic [3:0]  cnt_d;
   logic        own_data_q;
   logic        we_q;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic        mem_we_q;
   logic        i_ack_q;
   logic        d_ack_q;
   logic [31:0] i_rdata_q;
   logic [31:0] d_rdata_q;
   logic        grant_data_d;

`ifdef MEM_ARBITER_ROUND_ROBIN_EN
   // 1 = data was granted most recently; reset value favours data on first contest
   logic        last_data_q;
`endif

   always_comb begin
      grant_data_d = d_req;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
      if (d_req && i_req) begin
         grant_data_d = ~last_data_q;
      end
`endif
      cnt_d = cnt_q + 4'd1;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q    <= ST_IDLE;
         cnt_q      <= 4'd0;
         own_data_q <= 1'b0;
         we_q       <= 1'b0;
         addr_q     <= 32'd0;
         wdata_q    <= 32'd0;
         mem_we_q   <= 1'b0;
         i_ack_q    <= 1'b0;
         d_ack_q    <= 1'b0;
         i_rdata_q  <= 32'd0;
         d_rdata_q  <= 32'd0;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
         last_data_q <= 1'b0;
`endif
      end else begin
         mem_we_q <= 1'b0;
         i_ack_q  <= 1'b0;
         d_ack_q  <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (i_req || d_req) begin
                  state_q    <= ST_ACCESS;
                  cnt_q      <= 4'd0;
                  own_data_q <= grant_data_d;
                  addr_q     <= grant_data_d ? d_addr : i_addr;
                  wdata_q    <= grant_data_d ? d_wdata : 32'd0;
                  we_q       <= grant_data_d & d_we;
                  mem_we_q   <= grant_data_d & d_we;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
                  last_data_q <= grant_data_d;
`endif
               end
            end
            ST_ACCESS: begin
               cnt_q <= cnt_d;
               if (cnt_d == C_LAT) begin
                  state_q <= ST_ACK;
                  if (!we_q) begin
                     if (own_data_q) begin
                        d_rdata_q <= mem_rdata;
                     end else begin
                        i_rdata_q <= mem_rdata;
                     end
                  end
                  d_ack_q <= own_data_q;
                  i_ack_q <= ~own_data_q;
               end
            end
            ST_ACK: begin
               state_q <= ST_IDLE;
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign mem_we    = mem_we_q;
   assign i_ack     = i_ack_q;
   assign d_ack     = d_ack_q;
   assign i_rdata   = i_rdata_q;
   assign d_rdata   = d_rdata_q;
   assign busy      = (state_q != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ============================================================================
// tb_mem_arbiter: directed checks of mem_arbiter at MEM_LATENCY 1, 2 and 3.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_mem_arbiter;

`ifdef MEM_ARBITER_ROUND_ROBIN_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n   [3];
   logic        i_req   [3];
   logic [31:0] i_addr  [3];
   logic [31:0] i_rdata [3];
   logic        i_ack   [3];
   logic        d_req   [3];
   logic        d_we    [3];
   logic [31:0] d_addr  [3];
   logic [31:0] d_wdata [3];
   logic [31:0] d_rdata [3];
   logic        d_ack   [3];
   logic [31:0] m_addr  [3];
   logic [31:0] m_wdata [3];
   logic        m_we    [3];
   logic [31:0] m_rdata [3];
   logic        busy    [3];

   int n_total = 0;
   int n_bad   = 0;

   always #5 clk = ~clk;

   // Memory image: one fixed instruction word, everything else address-derived
   function automatic logic [31:0] memf(input logic [31:0] a);
      return (a == 32'h10) ? 32'h0050_0093 : (a ^ 32'hA5A5_0000);
   endfunction

   assign m_rdata[0] = memf(m_addr[0]);
   assign m_rdata[1] = memf(m_addr[1]);
   assign m_rdata[2] = memf(m_addr[2]);

   mem_arbiter #(.MEM_LATENCY(1)) u_l1 (
      .clk(clk), .reset(rst_n[0]),
      .i_req(i_req[0]), .i_addr(i_addr[0]), .i_rdata(i_rdata[0]), .i_ack(i_ack[0]),
      .d_req(d_req[0]), .d_we(d_we[0]), .d_addr(d_addr[0]), .d_wdata(d_wdata[0]),
      .d_rdata(d_rdata[0]), .d_ack(d_ack[0]),
      .mem_addr(m_addr[0]), .mem_wdata(m_wdata[0]), .mem_we(m_we[0]),
      .mem_rdata(m_rdata[0]), .busy(busy[0]));

   mem_arbiter #(.MEM_LATENCY(2)) u_l2 (
      .clk(clk), .reset(rst_n[1]),
      .i_req(i_req[1]), .i_addr(i_addr[1]), .i_rdata(i_rdata[1]), .i_ack(i_ack[1]),
      .d_req(d_req[1]), .d_we(d_we[1]), .d_addr(d_addr[1]), .d_wdata(d_wdata[1]),
      .d_rdata(d_rdata[1]), .d_ack(d_ack[1]),
      .mem_addr(m_addr[1]), .mem_wdata(m_wdata[1]), .mem_we(m_we[1]),
      .mem_rdata(m_rdata[1]), .busy(busy[1]));

   mem_arbiter #(.MEM_LATENCY(3)) u_l3 (
      .clk(clk), .reset(rst_n[2]),
      .i_req(i_req[2]), .i_addr(i_addr[2]), .i_rdata(i_rdata[2]), .i_ack(i_ack[2]),
      .d_req(d_req[2]), .d_we(d_we[2]), .d_addr(d_addr[2]), .d_wdata(d_wdata[2]),
      .d_rdata(d_rdata[2]), .d_ack(d_ack[2]),
      .mem_addr(m_addr[2]), .mem_wdata(m_wdata[2]), .mem_we(m_we[2]),
      .mem_rdata(m_rdata[2]), .busy(busy[2]));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      for (int k = 0; k < 3; k++) begin
         rst_n[k] = 1'b0; i_req[k] = 1'b0; i_addr[k] = '0;
         d_req[k] = 1'b0; d_we[k] = 1'b0; d_addr[k] = '0; d_wdata[k] = '0;
      end
      tick(); tick();
      chk("rst_busy",    32'(busy[0]),   32'd0);
      chk("rst_iack",    32'(i_ack[0]),  32'd0);
      chk("rst_dack",    32'(d_ack[0]),  32'd0);
      chk("rst_we",      32'(m_we[0]),   32'd0);
      chk("rst_irdata",  i_rdata[0],     32'd0);
      chk("rst_drdata",  d_rdata[0],     32'd0);
      chk("rst_addr",    m_addr[0],      32'd0);
      for (int k = 0; k < 3; k++) rst_n[k] = 1'b1;

      // Round A: contested, data wins on both builds (flag starts at instruction)
      i_req[0] = 1'b1; i_addr[0] = 32'h40;
      d_req[0] = 1'b1; d_we[0] = 1'b0; d_addr[0] = 32'h80;
      tick();
      chk("ra_c1_addr",  m_addr[0],      32'h80);
      chk("ra_c1_busy",  32'(busy[0]),   32'd1);
      tick();
      chk("ra_c2_dack",  32'(d_ack[0]),  32'd1);
      chk("ra_c2_iack",  32'(i_ack[0]),  32'd0);
      chk("ra_c2_drd",   d_rdata[0],     32'hA5A5_0080);
      d_req[0] = 1'b0;
      tick();
      chk("ra_c3_busy",  32'(busy[0]),   32'd0);
      tick();
      chk("ra_c4_addr",  m_addr[0],      32'h40);
      tick();
      chk("ra_c5_iack",  32'(i_ack[0]),  32'd1);
      chk("ra_c5_dack",  32'(d_ack[0]),  32'd0);
      chk("ra_c5_ird",   i_rdata[0],     32'hA5A5_0040);
      i_req[0] = 1'b0;
      tick();
      chk("ra_c6_busy",  32'(busy[0]),   32'd0);

      // Round B: data wins, then re-requests back-to-back against a waiting fetch
      i_req[0] = 1'b1; i_addr[0] = 32'h40;
      d_req[0] = 1'b1; d_addr[0] = 32'h88;
      tick();
      chk("rb_c1_addr",  m_addr[0],      32'h88);
      tick();
      chk("rb_c2_dack",  32'(d_ack[0]),  32'd1);
      d_addr[0] = 32'h8C;
      tick();
      chk("rb_c3_busy",  32'(busy[0]),   32'd0);
      tick();
      chk("rb_c4_addr",  m_addr[0],      RR ? 32'h40 : 32'h8C);
      tick();
      chk("rb_c5_iack",  32'(i_ack[0]),  RR ? 32'd1 : 32'd0);
      chk("rb_c5_dack",  32'(d_ack[0]),  RR ? 32'd0 : 32'd1);
      if (i_ack[0]) i_req[0] = 1'b0;
      if (d_ack[0]) d_req[0] = 1'b0;
      tick(); tick();
      chk("rb_c7_addr",  m_addr[0],      RR ? 32'h8C : 32'h40);
      tick();
      chk("rb_c8_iack",  32'(i_ack[0]),  RR ? 32'd0 : 32'd1);
      chk("rb_c8_dack",  32'(d_ack[0]),  RR ? 32'd1 : 32'd0);
      chk("rb_c8_drd",   d_rdata[0],     32'hA5A5_008C);
      i_req[0] = 1'b0; d_req[0] = 1'b0;
      tick();

      // Simple fetch, latency 1
      i_req[0] = 1'b1; i_addr[0] = 32'h10;
      chk("f_c0_busy",   32'(busy[0]),   32'd0);
      tick();
      chk("f_c1_addr",   m_addr[0],      32'h10);
      chk("f_c1_we",     32'(m_we[0]),   32'd0);
      chk("f_c1_iack",   32'(i_ack[0]),  32'd0);
      tick();
      chk("f_c2_iack",   32'(i_ack[0]),  32'd1);
      chk("f_c2_we",     32'(m_we[0]),   32'd0);
      chk("f_c2_ird",    i_rdata[0],     32'h0050_0093);
      i_req[0] = 1'b0;
      tick();
      chk("f_c3_busy",   32'(busy[0]),   32'd0);
      chk("f_c3_iack",   32'(i_ack[0]),  32'd0);

      // Store, latency 1
      d_req[0] = 1'b1; d_we[0] = 1'b1; d_addr[0] = 32'h200; d_wdata[0] = 32'hDEAD_BEEF;
      tick();
      chk("s_c1_we",     32'(m_we[0]),   32'd1);
      chk("s_c1_addr",   m_addr[0],      32'h200);
      chk("s_c1_wdata",  m_wdata[0],     32'hDEAD_BEEF);
      tick();
      chk("s_c2_we",     32'(m_we[0]),   32'd0);
      chk("s_c2_dack",   32'(d_ack[0]),  32'd1);
      chk("s_c2_iack",   32'(i_ack[0]),  32'd0);
      chk("s_c2_drd",    d_rdata[0],     32'hA5A5_008C);
      chk("s_c2_ird",    i_rdata[0],     32'h0050_0093);
      d_req[0] = 1'b0; d_we[0] = 1'b0;
      tick();
      chk("s_c3_busy",   32'(busy[0]),   32'd0);

      // Latency 2: fetch request dropped after being sampled
      i_req[1] = 1'b1; i_addr[1] = 32'h20;
      tick();
      i_req[1] = 1'b0;
      tick();
      chk("l2_c2_iack",  32'(i_ack[1]),  32'd0);
      chk("l2_c2_busy",  32'(busy[1]),   32'd1);
      tick();
      chk("l2_c3_iack",  32'(i_ack[1]),  32'd1);
      chk("l2_c3_ird",   i_rdata[1],     32'hA5A5_0020);
      tick();
      chk("l2_c4_busy",  32'(busy[1]),   32'd0);
      chk("l2_c4_iack",  32'(i_ack[1]),  32'd0);

      // Latency 3: reset asserted in the second access cycle
      i_req[2] = 1'b1; i_addr[2] = 32'h10;
      tick();
      tick();
      chk("l3_c2_busy",  32'(busy[2]),   32'd1);
      rst_n[2] = 1'b0;
      tick();
      chk("l3_c3_busy",  32'(busy[2]),   32'd0);
      chk("l3_c3_iack",  32'(i_ack[2]),  32'd0);
      chk("l3_c3_ird",   i_rdata[2],     32'd0);
      chk("l3_c3_drd",   d_rdata[2],     32'd0);
      i_req[2] = 1'b0; rst_n[2] = 1'b1;
      tick();
      chk("l3_c4_iack",  32'(i_ack[2]),  32'd0);
      tick(); tick();
      chk("l3_c6_iack",  32'(i_ack[2]),  32'd0);
      chk("l3_c6_ird",   i_rdata[2],     32'd0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

`default_nettype wire
